stage_id_regread: RTL and testbench
===================================

# stage_ID_regread

Register-file read side of the LC-3b pipeline, sitting in the decode (ID) stage and consuming the writeback stream produced by the WB stage. It holds the eight 16-bit architectural registers, serves two combinational read ports with same-cycle write-through bypass from WB, and keeps a per-register scoreboard of in-flight writes. When an operand is not yet written back, it raises a stall to the decode stage.

## Interface
Parameters:
- MAX_PENDING, 3, maximum in-flight writes tracked per register. Counters are 2 bits wide.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_dest  input  3 (lc3b_reg)  writeback destination register.
- wr_data  input  16 (lc3b_word)  writeback data.
- wr_load  input  1  writeback strobe; one register write per cycle.
- sr1  input  3  source register 1 address.
- sr2  input  3  source register 2 address.
- sr1_used  input  1  the decoding instruction reads sr1.
- sr2_used  input  1  the decoding instruction reads sr2.
- issue_valid  input  1  the decoding instruction attempts to leave ID this cycle.
- issue_load  input  1  the issuing instruction will write a register.
- issue_dest  input  3  destination of the issuing instruction (already resolved, including R7 for JSR/TRAP).
- sr1_data  output  16  register or bypassed value for sr1.
- sr2_data  output  16  register or bypassed value for sr2.
- stall  output  1  the issue is refused this cycle.
- underflow_err  output  1  sticky flag: a write arrived for a register with no pending entry.

## Operation
- Storage: 8 x 16-bit registers R0..R7, plus 8 x 2-bit pending counters pend[r].
- Read:
  - sr1_data = (wr_load && wr_dest==sr1) ? wr_data : R[sr1]. sr2_data follows the same rule.
  - Reads are purely combinational.
- Write: on a clock edge with wr_load=1, R[wr_dest] <= wr_data.
- Effective pending: eff[r] = pend[r] - (wr_load && wr_dest==r). This value is combinational and never negative. A write with pend[r]==0 counts as 0 here.
- Operand hazard: haz1 = sr1_used && eff[sr1]!=0. haz2 follows the same rule for sr2.
- Capacity hazard: hazc = issue_load && eff[issue_dest]==MAX_PENDING.
- stall = issue_valid && (haz1 || haz2 || hazc). stall is 0 whenever issue_valid=0.
- Accepted issue: acc = issue_valid && !stall && issue_load.
- Counter update, applied per register r at the clock edge:
  - inc = acc && issue_dest==r.
  - dec = wr_load && wr_dest==r && pend[r]!=0.
  - pend[r] <= pend[r] + inc - dec.
  - When inc and dec hit the same register, the counter is unchanged.
- Underflow: wr_load with pend[wr_dest]==0 still writes the register. It leaves the counter at 0 and sets underflow_err, which clears only on reset.
- R0 is an ordinary register; the LC-3b has no hardwired zero.

## Timing
- Reset (reset_n=0, asynchronous):
  - All R[r] = 0x0000, all pend[r] = 0, underflow_err = 0.
  - Outputs then follow from these values: sr*_data = 0 unless bypassed, and stall = 0 with no pending writes.
- Reset deasserted mid-operation: there is no recovery of in-flight state. WB writes that arrive afterwards for earlier instructions set underflow_err.
- Read latency is 0 cycles: combinational from sr*/wr_* to sr*_data.
- A register written at edge N is visible from R[] after edge N. During cycle N it is visible only through the bypass.
- stall is combinational in the same cycle. The decode stage holds the instruction and re-presents issue_valid until stall=0.
- A dependent instruction issues in the cycle its producer is in WB, because the bypass together with eff makes the stall drop in that cycle.
- Simultaneous events in one cycle (issue to r, WB to r, read of r): the read returns wr_data and is not stalled by the retiring write. The counter is unchanged.

## Test plan
- Reset mid-run with R3=0x1234 and pend[3]=1 -> R3=0, pend=0, stall=0 and underflow_err=0 immediately, without waiting for clk.
- Issue ADD with dest R2 (pend[2] goes 0->1), then decode an instruction with sr1=R2, sr1_used=1 -> stall=1 until the cycle with wr_load=1, wr_dest=2, wr_data=0xBEEF. In that cycle stall=0 and sr1_data=0xBEEF; the next cycle R2 reads 0xBEEF.
- Issue three writes to R5 with no retire -> pend[5]=3. A fourth issue with issue_dest=5 gives stall=1. In a cycle where wr_dest=5 retires, the fourth issue is accepted and pend[5] stays 3.
- JSR-style issue with dest R7 accepted in the same cycle that WB retires an older R7 write, pend[7] at 1 -> pend[7] stays 1. A reader of R7 gets wr_data that cycle and stalls the next cycle.
- wr_load=1, wr_dest=4, pend[4]=0, wr_data=0x00FF -> R4=0x00FF, pend[4]=0, underflow_err=1 and held through later traffic.
- sr1=sr2=R6 with sr2_used=0, pend[6]=1, sr1_used=1 -> stall=1. With sr1_used=0 as well -> stall=0.

Source files
------------

// File: rtl/stage_id_regread.sv
// stage_id_regread: LC-3b ID-stage register file with WB bypass and per-register pending-write scoreboard.
module stage_id_regread #(
  parameter int MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  wr_dest,
  input  logic [15:0] wr_data,
  input  logic        wr_load,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic        sr1_used,
  input  logic        sr2_used,
  input  logic        issue_valid,
  input  logic        issue_load,
  input  logic [2:0]  issue_dest,
  output logic [15:0] sr1_data,
  output logic [15:0] sr2_data,
  output logic        stall,
  output logic        underflow_err
);
  logic [15:0] r_regs [8];
  logic [1:0]  r_pend [8];
  logic        r_uflow;
  logic [7:0]  w_dec;
  logic [1:0]  w_eff [8];
  logic        w_haz1, w_haz2, w_hazc, w_acc;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_dec[i] = wr_load && wr_dest == 3'(i) && r_pend[i] != 2'd0;
      w_eff[i] = r_pend[i] - {1'b0, w_dec[i]};
    end
  end
  assign sr1_data      = (wr_load && wr_dest == sr1) ? wr_data : r_regs[sr1];
  assign sr2_data      = (wr_load && wr_dest == sr2) ? wr_data : r_regs[sr2];
  assign w_haz1        = sr1_used && w_eff[sr1] != 2'd0;
  assign w_haz2        = sr2_used && w_eff[sr2] != 2'd0;
  assign w_hazc        = issue_load && w_eff[issue_dest] == 2'(MAX_PENDING);
  assign stall         = issue_valid && (w_haz1 || w_haz2 || w_hazc);
  assign w_acc         = issue_valid && !stall && issue_load;
  assign underflow_err = r_uflow;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0000;
        r_pend[i] <= 2'd0;
      end
      r_uflow <= 1'b0;
    end else begin
      if (wr_load) r_regs[wr_dest] <= wr_data;
      // a retire with nothing pending still writes but flags the scoreboard as out of sync
      if (wr_load && !w_dec[wr_dest]) r_uflow <= 1'b1;
      for (int i = 0; i < 8; i++)
        r_pend[i] <= r_pend[i] + {1'b0, w_acc && issue_dest == 3'(i)} - {1'b0, w_dec[i]};
    end
  end
endmodule

// File: tb/tb_stage_id_regread.sv
// tb_stage_id_regread: randomized and directed checks of stage_id_regread against a behavioural scoreboard model.
module tb_stage_id_regread;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [2:0]  wr_dest = 0, sr1 = 0, sr2 = 0, issue_dest = 0;
  logic [15:0] wr_data = 0;
  logic        wr_load = 0, sr1_used = 0, sr2_used = 0, issue_valid = 0, issue_load = 0;
  logic [15:0] sr1_data, sr2_data;
  logic        stall, underflow_err;
  int checks = 0, errors = 0;
  int m_regs [8];
  int m_pend [8];
  int m_uflow;

  stage_id_regread #(.MAX_PENDING(3)) dut (
    .clk(clk), .reset_n(reset_n), .wr_dest(wr_dest), .wr_data(wr_data), .wr_load(wr_load),
    .sr1(sr1), .sr2(sr2), .sr1_used(sr1_used), .sr2_used(sr2_used), .issue_valid(issue_valid),
    .issue_load(issue_load), .issue_dest(issue_dest), .sr1_data(sr1_data), .sr2_data(sr2_data),
    .stall(stall), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int r);
    return m_pend[r] - ((wr_load && int'(wr_dest) == r && m_pend[r] > 0) ? 1 : 0);
  endfunction

  function automatic int rd(input int r);
    return (wr_load && int'(wr_dest) == r) ? int'(wr_data) : m_regs[r];
  endfunction

  function automatic bit exp_stall();
    return issue_valid && ((sr1_used && eff(sr1) != 0) || (sr2_used && eff(sr2) != 0) ||
                           (issue_load && eff(issue_dest) == 3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_uflow = 0;
  endtask

  task automatic apply();
    bit s;
    s = exp_stall();
    chk("sr1_data", sr1_data, rd(sr1));
    chk("sr2_data", sr2_data, rd(sr2));
    chk("stall", stall, s);
    chk("underflow", underflow_err, m_uflow);
    if (wr_load) begin
      m_regs[wr_dest] = wr_data;
      if (m_pend[wr_dest] == 0) m_uflow = 1;
      else m_pend[wr_dest]--;
    end
    if (issue_valid && !s && issue_load) m_pend[issue_dest]++;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit wl, input int wd, input int wv, input int s1, input int s2,
                     input bit u1, input bit u2, input bit iv, input bit il, input int id);
    wr_load = wl; wr_dest = 3'(wd); wr_data = 16'(wv);
    sr1 = 3'(s1); sr2 = 3'(s2); sr1_used = u1; sr2_used = u2;
    issue_valid = iv; issue_load = il; issue_dest = 3'(id);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_sr1", sr1_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_uflow", underflow_err, 0);
    reset_n = 1;
    #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    #1;
    // mid-run reset with R3=0x1234 and one write to R3 still pending
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 3); apply();
    drv(1, 3, 16'h1234, 0, 0, 0, 0, 1, 1, 3); apply();
    drv(0, 0, 0, 3, 3, 1, 0, 1, 0, 0);
    chk("pre_rst_r3", sr1_data, 16'h1234);
    chk("pre_rst_stall", stall, 1);
    do_reset();
    // RAW on R2 resolved by WB bypass
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 2); apply();
    drv(0, 0, 0, 2, 0, 1, 0, 1, 0, 0); chk("raw_stall", stall, 1); apply();
    apply();
    drv(1, 2, 16'hBEEF, 2, 0, 1, 0, 1, 0, 0);
    chk("raw_bypass", sr1_data, 16'hBEEF); chk("raw_go", stall, 0); apply();
    drv(0, 0, 0, 2, 0, 1, 0, 1, 0, 0); chk("raw_reg", sr1_data, 16'hBEEF); apply();
    // capacity limit on R5
    for (int k = 0; k < 3; k++) begin drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 5); apply(); end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 5); chk("cap_stall", stall, 1); apply();
    drv(1, 5, 16'h5555, 0, 0, 0, 0, 1, 1, 5); chk("cap_retire", stall, 0); apply();
    for (int k = 0; k < 3; k++) begin drv(1, 5, k, 0, 0, 0, 0, 0, 0, 0); apply(); end
    drv(0, 0, 0, 5, 0, 1, 0, 1, 0, 0); chk("cap_drained", stall, 0); apply();
    // JSR to R7 while an older R7 write retires
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 7); apply();
    drv(1, 7, 16'h3000, 7, 0, 1, 0, 1, 1, 7);
    chk("jsr_bypass", sr1_data, 16'h3000); chk("jsr_stall", stall, 0); apply();
    drv(0, 0, 0, 7, 0, 1, 0, 1, 0, 0); chk("jsr_next", stall, 1); apply();
    drv(1, 7, 16'h3002, 0, 0, 0, 0, 0, 0, 0); apply();
    // underflow write to R4
    drv(1, 4, 16'h00FF, 0, 0, 0, 0, 0, 0, 0); apply();
    drv(0, 0, 0, 4, 4, 1, 1, 1, 0, 0);
    chk("uf_r4", sr1_data, 16'h00FF); chk("uf_flag", underflow_err, 1); chk("uf_nostall", stall, 0); apply();
    // sr2 unused masks its hazard
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 6); apply();
    drv(0, 0, 0, 6, 6, 1, 0, 1, 0, 0); chk("r6_u1", stall, 1); apply();
    drv(0, 0, 0, 6, 6, 0, 0, 1, 0, 0); chk("r6_none", stall, 0); apply();
    chk("uf_held", underflow_err, 1);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int wd; bit wl;
      wd = $urandom_range(0, 7);
      wl = $urandom_range(0, 2) != 0;
      if (wl && m_pend[wd] == 0 && $urandom_range(0, 40) != 0) begin
        wl = 0;
        for (int r = 0; r < 8; r++) if (m_pend[r] > 0) begin wd = r; wl = 1; end
      end
      drv(wl, wd, $urandom_range(0, 65535), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1), $urandom_range(0, 7));
      apply();
      if (n == 1500) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
